// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache line transfer engine.
package cache_pkg;

  // Default cache geometry; module parameters start from these.
  localparam int CACHE_ADDR_WIDTH     = 32;
  localparam int CACHE_DATA_WIDTH     = 32;
  localparam int CACHE_LINE_WORDS     = 4;
  localparam int CACHE_TIMEOUT_CYCLES = 64;

  // Derived geometry for the default configuration.
  localparam int WORD_BYTES  = CACHE_DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(CACHE_LINE_WORDS * WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } xfer_state_e;

  // Clear the line-offset bits of a byte address (callers truncate to their width).
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_bits);
    logic [63:0] mask;
    mask = {64{1'b1}} << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_xfer_wdog.sv
// Watchdog for a held memory request: flags expiry on the TIMEOUT_CYCLES-th
// consecutive cycle a request is held without ready.
module cache_xfer_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held,
  input  logic ready,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count held-without-ready cycles; any ready or idle cycle restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n || !held || ready) cnt <= '0;
    else if (!expire)             cnt <= cnt + 1'b1;
  end

  assign expire = held && !ready && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cache_line_xfer.sv
// Line transfer engine: writes back a victim line and/or refills a line as a
// sequence of single-word requests on a ready-handshaked memory port.
// Optional watchdog: define CACHE_XFER_TIMEOUT_EN to abort requests that are
// held TIMEOUT_CYCLES cycles without mem_ready (sets sticky err).
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CACHE_DATA_WIDTH,
  parameter int LINE_WORDS     = CACHE_LINE_WORDS,
  parameter int TIMEOUT_CYCLES = CACHE_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wb,
  input  logic                             req_fill,
  input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
  input  logic [ADDR_WIDTH-1:0]            req_fill_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wb_line,
  output logic                             fill_we,
  output logic [$clog2(LINE_WORDS)-1:0]    fill_idx,
  output logic [DATA_WIDTH-1:0]            fill_word,
  output logic                             done,
  output logic                             err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [DATA_WIDTH/8-1:0]          mem_wstrb,
  output logic                             mem_write,
  output logic                             mem_read,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready
);
  localparam int WBYTES = DATA_WIDTH / 8;
  localparam int OBITS  = $clog2(LINE_WORDS * WBYTES);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(LINE_WORDS - 1);

  // Reject geometries the address/index arithmetic cannot represent, and keep
  // the local derivation in step with the package for the default geometry.
  if (TIMEOUT_CYCLES < 1 || LINE_WORDS < 2 || (DATA_WIDTH % 8) != 0 || ADDR_WIDTH > 64 ||
      (DATA_WIDTH == CACHE_DATA_WIDTH && LINE_WORDS == CACHE_LINE_WORDS &&
       (WBYTES != WORD_BYTES || OBITS != OFFSET_BITS))) begin : g_bad_cfg
    $error("cache_line_xfer: unsupported parameter set");
  end

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input idx_t i);
    return base + ADDR_WIDTH'(i) * ADDR_WIDTH'(WBYTES);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] line_word(input logic [LINE_W-1:0] ln, input idx_t i);
    return ln[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  xfer_state_e             state_q, state_d;
  idx_t                    idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   wb_base_q, wb_base_d, fill_base_q, fill_base_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    do_fill_q, do_fill_d;

  logic                    mem_read_d, mem_write_d, fill_we_d, done_d, err_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d, fill_word_d;
  logic [WBYTES-1:0]       mem_wstrb_d;
  idx_t                    fill_idx_d;
  logic                    expire;

`ifdef CACHE_XFER_TIMEOUT_EN
  cache_xfer_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .held   (mem_read | mem_write),
    .ready  (mem_ready),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);

  // Next-state and next-output logic; every output leaves through a flop.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    line_d      = line_q;
    do_fill_d   = do_fill_q;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    fill_we_d   = 1'b0;
    fill_idx_d  = fill_idx;
    fill_word_d = fill_word;
    done_d      = 1'b0;
    err_d       = err;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wb_base_d   = ADDR_WIDTH'(line_base(64'(req_wb_addr), OBITS));
          fill_base_d = ADDR_WIDTH'(line_base(64'(req_fill_addr), OBITS));
          line_d      = req_wb_line;
          do_fill_d   = req_fill;
          idx_d       = '0;
          if (req_wb) begin
            state_d     = WB;
            mem_write_d = 1'b1;
            mem_wstrb_d = '1;
            mem_addr_d  = wb_base_d;
            mem_wdata_d = line_word(req_wb_line, '0);
          end else if (req_fill) begin
            state_d     = FILL;
            mem_read_d  = 1'b1;
            mem_wstrb_d = '0;
            mem_addr_d  = fill_base_d;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      WB: begin
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            mem_write_d = 1'b0;
            mem_wstrb_d = '0;
            if (do_fill_q) begin
              state_d    = FILL;
              mem_read_d = 1'b1;
              mem_addr_d = fill_base_q;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d       = idx_q + 1'b1;
            mem_addr_d  = word_addr(wb_base_q, idx_d);
            mem_wdata_d = line_word(line_q, idx_d);
          end
        end else if (expire) begin
          state_d     = DONE;
          done_d      = 1'b1;
          err_d       = 1'b1;
          idx_d       = '0;
          mem_write_d = 1'b0;
          mem_wstrb_d = '0;
        end
      end

      FILL: begin
        if (mem_ready) begin
          fill_we_d   = 1'b1;
          fill_word_d = mem_rdata;
          fill_idx_d  = idx_q;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            mem_read_d = 1'b0;
            state_d    = DONE;
            done_d     = 1'b1;
          end else begin
            idx_d      = idx_q + 1'b1;
            mem_addr_d = word_addr(fill_base_q, idx_d);
          end
        end else if (expire) begin
          state_d    = DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          idx_d      = '0;
          mem_read_d = 1'b0;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command and registered outputs; reset aborts any command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wb_base_q   <= '0;
      fill_base_q <= '0;
      line_q      <= '0;
      do_fill_q   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      fill_we     <= 1'b0;
      fill_idx    <= '0;
      fill_word   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
      line_q      <= line_d;
      do_fill_q   <= do_fill_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      mem_wstrb   <= mem_wstrb_d;
      fill_we     <= fill_we_d;
      fill_idx    <= fill_idx_d;
      fill_word   <= fill_word_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Bench for cache_line_xfer: a memory model plus an expected-transaction queue
// checks every cycle; directed cases pin addresses, data and latencies.
module tb_cache_line_xfer;
  localparam int AW = 32, DW = 32, LW = 4, TO = 64;
  localparam int LINE_BITS = LW * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, req_valid, req_ready, req_wb, req_fill;
  logic [AW-1:0]        req_wb_addr, req_fill_addr;
  logic [LINE_BITS-1:0] req_wb_line;
  logic                 fill_we, done, err;
  logic [1:0]           fill_idx;
  logic [DW-1:0]        fill_word, mem_wdata, mem_rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW/8-1:0]      mem_wstrb;
  logic                 mem_write, mem_read, mem_ready;

  cache_line_xfer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill), .req_wb_addr(req_wb_addr),
    .req_fill_addr(req_fill_addr), .req_wb_line(req_wb_line),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_word(fill_word), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem_model [bit [31:0]];
  logic [31:0] ra_log[$], wa_log[$], wd_log[$], fw_log[$];

  int   vectors = 0, fails = 0;
  bit   active, idle_now, hs_prev, hs_rd, err_exp, to_pend, post_rst, rst_req, rst_on_word2;
  int   hs_idx, hold_cnt, cur_lat, mode, cyc, last_lat, done_cnt;
  logic [31:0] hs_data;
  bit   cmd_pending, c_wb, c_fl;
  logic [31:0] c_wa, c_fa;
  logic [LINE_BITS-1:0] c_line;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pick_lat();
    case (mode)
      0:       return $urandom_range(0, 3);
      3:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_fill_we", fill_we, 1'b0);
    chk("rst_fill_idx", fill_idx, 0);
    chk("rst_fill_word", fill_word, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
  endtask

  task automatic finish_cmd();
    active   = 0;
    last_lat = cyc;
    done_cnt++;
  endtask

  // Compare the DUT outputs visible this cycle against the model.
  task automatic check_cycle();
    logic rq;
    rq = mem_read | mem_write;
    if (post_rst) begin chk_reset_vals(); post_rst = 0; end
    if (active) cyc++;
    chk("rw_exclusive", mem_read & mem_write, 1'b0);
    if (hs_prev && hs_rd) begin
      chk("fill_we", fill_we, 1'b1);
      chk("fill_idx", fill_idx, hs_idx);
      chk("fill_word", fill_word, hs_data);
      fw_log.push_back(fill_word);
    end else chk("fill_we_quiet", fill_we, 1'b0);
    hs_prev  = 0;
    chk("err", err, err_exp);
    idle_now = 0;
    if (to_pend) begin
      chk("done_on_timeout", done, 1'b1);
      chk("req_dropped", rq, 1'b0);
      to_pend = 0;
      finish_cmd();
    end else if (active && exp_q.size() > 0) begin
      chk("req_ready_busy", req_ready, 1'b0);
      chk("done_busy", done, 1'b0);
      chk("mem_write", mem_write, exp_q[0].wr);
      chk("mem_read", mem_read, !exp_q[0].wr);
      chk("mem_addr", mem_addr, exp_q[0].addr);
      if (exp_q[0].wr) begin
        chk("mem_wdata", mem_wdata, exp_q[0].data);
        chk("mem_wstrb_wr", mem_wstrb, 4'hF);
      end else chk("mem_wstrb_rd", mem_wstrb, 4'h0);
    end else if (active) begin
      chk("done", done, 1'b1);
      chk("no_req_at_done", rq, 1'b0);
      chk("req_ready_at_done", req_ready, 1'b0);
      finish_cmd();
    end else begin
      chk("done_idle", done, 1'b0);
      chk("no_req_idle", rq, 1'b0);
      chk("req_ready_idle", req_ready, 1'b1);
      idle_now = 1;
    end
  endtask

  // Drive memory response, reset and command inputs for the coming edge.
  task automatic drive();
    logic rdy;
    bit   do_rst;
    txn_t t;
    logic [31:0] base;
    do_rst = rst_req || (rst_on_word2 && active && exp_q.size() > 0 &&
                         !exp_q[0].wr && exp_q[0].idx == 1);
    if (do_rst) begin
      rst_n = 0; rst_req = 0; rst_on_word2 = 0;
      mem_ready = 1; mem_rdata = $urandom(); req_valid = 0;
      active = 0; exp_q.delete(); err_exp = 0; to_pend = 0; hold_cnt = 0;
      hs_prev = 0; post_rst = 1;
      return;
    end
    rst_n = 1;
    rdy   = 0;
    if (active && exp_q.size() > 0) begin
      if (mode != 2 && hold_cnt >= cur_lat) begin
        rdy = 1; hs_prev = 1; hs_rd = !exp_q[0].wr; hs_idx = exp_q[0].idx;
        if (exp_q[0].wr) begin
          mem_model[exp_q[0].addr] = exp_q[0].data;
          wa_log.push_back(exp_q[0].addr);
          wd_log.push_back(exp_q[0].data);
        end else begin
          hs_data = mem_rd(exp_q[0].addr);
          ra_log.push_back(exp_q[0].addr);
        end
        void'(exp_q.pop_front());
        hold_cnt = 0;
        cur_lat  = pick_lat();
      end else begin
        hold_cnt++;
`ifdef CACHE_XFER_TIMEOUT_EN
        if (hold_cnt == TO) begin to_pend = 1; err_exp = 1; exp_q.delete(); end
`endif
      end
    end else rdy = 1'($urandom_range(0, 1));
    mem_ready = rdy;
    mem_rdata = rdy ? mem_rd(mem_addr) : $urandom();

    if (idle_now && cmd_pending) begin
      req_valid = 1; req_wb = c_wb; req_fill = c_fl;
      req_wb_addr = c_wa; req_fill_addr = c_fa; req_wb_line = c_line;
      if (c_wb) begin
        base = c_wa & ~32'(LW * DW / 8 - 1);
        for (int i = 0; i < LW; i++) begin
          t.wr = 1; t.addr = base + 32'(i * 4); t.data = c_line[i*DW +: DW]; t.idx = i;
          exp_q.push_back(t);
        end
      end
      if (c_fl) begin
        base = c_fa & ~32'(LW * DW / 8 - 1);
        for (int i = 0; i < LW; i++) begin
          t.wr = 0; t.addr = base + 32'(i * 4); t.data = 0; t.idx = i;
          exp_q.push_back(t);
        end
      end
      active = 1; cyc = 0; cmd_pending = 0; hold_cnt = 0; cur_lat = pick_lat();
    end else begin
      // Noise on the command inputs: ignored while busy, and held off while idle.
      req_valid     = idle_now ? 1'b0 : 1'($urandom_range(0, 1));
      req_wb        = 1'($urandom_range(0, 1));
      req_fill      = 1'($urandom_range(0, 1));
      req_wb_addr   = $urandom();
      req_fill_addr = $urandom();
      req_wb_line   = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    drive();
  endtask

  task automatic run_cmd(input bit wb, input bit fl, input logic [31:0] wa, input logic [31:0] fa,
                         input logic [LINE_BITS-1:0] ln, input int m);
    mode = m; c_wb = wb; c_fl = fl; c_wa = wa; c_fa = fa; c_line = ln; cmd_pending = 1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (!cmd_pending && !active) return;
    end
    vectors++; fails++;
    $display("FAIL cmd_bound: command still open after 2000 cycles, want done");
    cmd_pending = 0; active = 0; exp_q.delete();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] off;
    off = 32'($urandom_range(0, 15));
    case ($urandom_range(0, 3))
      0:       return 32'h0000_1000 | off;
      1:       return 32'h0000_2040 | off;
      2:       return 32'hFFFF_FFF0 | off;
      default: return $urandom();
    endcase
  endfunction

  int d0;

  initial begin
    rst_n = 0; req_valid = 0; req_wb = 0; req_fill = 0; req_wb_addr = 0; req_fill_addr = 0;
    req_wb_line = 0; mem_rdata = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1;

    // Fill-only from 0x104, 5-cycle read latency.
    for (int i = 0; i < 4; i++) mem_model[32'h100 + 32'(4*i)] = 32'hC0DE_0000 + 32'(i);
    ra_log.delete(); fw_log.delete(); d0 = done_cnt;
    run_cmd(0, 1, 32'h0000_0104, 32'h0000_0104, '0, 3);
    chk("A_nreads", ra_log.size(), 4);
    for (int i = 0; i < ra_log.size(); i++) chk("A_read_addr", ra_log[i], 32'h100 + 32'(4*i));
    if (fw_log.size() == 4) chk("A_fill_word1", fw_log[1], 32'hC0DE_0001);
    else chk("A_nfills", fw_log.size(), 4);
    chk("A_done_once", done_cnt - d0, 1);

    // Writeback 0x200 then fill 0x300, random latency.
    ra_log.delete(); wa_log.delete(); wd_log.delete();
    run_cmd(1, 1, 32'h0000_0200, 32'h0000_0300,
            {32'hD333_0003, 32'hD222_0002, 32'hD111_0001, 32'hD000_0000}, 0);
    chk("B_nwrites", wa_log.size(), 4);
    chk("B_nreads", ra_log.size(), 4);
    for (int i = 0; i < wa_log.size(); i++) begin
      chk("B_wr_addr", wa_log[i], 32'h200 + 32'(4*i));
      chk("B_wr_data", wd_log[i], {4'hD, 4'(i), 4'(i), 4'(i), 16'(i)});
    end
    for (int i = 0; i < ra_log.size(); i++) chk("B_rd_addr", ra_log[i], 32'h300 + 32'(4*i));

    // Zero-wait latencies.
    run_cmd(1, 1, 32'h0000_4000, 32'h0000_5000, {4{$urandom()}}, 1);
    chk("C_wbfill_latency", last_lat, 9);
    run_cmd(0, 1, 32'h0000_4000, 32'h0000_6008, '0, 1);
    chk("C_fill_latency", last_lat, 5);
    ra_log.delete(); wa_log.delete();
    run_cmd(0, 0, 32'h0000_4000, 32'h0000_6008, '0, 0);
    chk("C_none_latency", last_lat, 1);
    chk("C_none_no_mem", ra_log.size() + wa_log.size(), 0);

    // Reset while the second fill word is held, then a normal command.
    fw_log.delete(); rst_on_word2 = 1;
    run_cmd(0, 1, 32'h0000_0740, 32'h0000_0740, '0, 3);
    tick();
    chk("D_fills_before_rst", fw_log.size(), 1);
    d0 = done_cnt;
    run_cmd(1, 1, 32'h0000_0740, 32'h0000_0740, {$urandom(), $urandom(), $urandom(), $urandom()}, 0);
    chk("D_recovered_done", done_cnt - d0, 1);

    // Randomized commands, including top-of-space lines.
    for (int k = 0; k < 40; k++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), pick_addr(),
              {$urandom(), $urandom(), $urandom(), $urandom()}, (k % 3 == 2) ? 3 : (k % 3));
    end

`ifdef CACHE_XFER_TIMEOUT_EN
    // Memory never ready: watchdog aborts after TO held cycles; err is sticky.
    d0 = done_cnt;
    run_cmd(0, 1, 32'h0000_8000, 32'h0000_8000, '0, 2);
    chk("E_timeout_latency", last_lat, TO + 1);
    chk("E_done_once", done_cnt - d0, 1);
    run_cmd(1, 1, 32'h0000_8000, 32'h0000_9000, {4{$urandom()}}, 0);
    chk("E_err_sticky", err, 1'b1);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
